// File: rtl/loader_pkg.sv
// Program loader shared types and word geometry.
// Optional checksum stage is enabled with LOADER_CHECKSUM_EN.
package loader_pkg;

  localparam int INSTR_WIDTH_DEF = 32;
  localparam int HEADER_BYTES    = 2;
  localparam int BYTES_PER_WORD  = INSTR_WIDTH_DEF / 8;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    LOAD,
    WRITE,
    CSUM,
    RUN,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte-to-word assembler with a one-cycle word-complete pulse.
// The completed word is held until the next word completes.
module byte_assembler
  import loader_pkg::*;
#(
  parameter int W   = 32,
  parameter int BPW = BYTES_PER_WORD
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic [7:0]   i_byte,
  output logic         o_last,
  output logic         o_valid,
  output logic [W-1:0] o_word
);

  localparam int CW = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_shift;
  logic [W-1:0]  r_word;
  logic          r_valid;
  logic [W-1:0]  w_shift_nxt;

  assign w_shift_nxt = (r_shift << 8) | W'(i_byte);
  assign o_last      = (r_cnt == CW'(BPW - 1));
  assign o_valid     = r_valid;
  assign o_word      = r_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_clear) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (i_push) begin
        r_shift <= w_shift_nxt;
        if (o_last) begin
          r_cnt   <= '0;
          r_word  <= w_shift_nxt;
          r_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a counted program into instruction memory, then runs the CPU
// until pc passes the last word. Checksum stage: LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  input  logic [ADDR_WIDTH-1:0]  pc,
  output logic                   cpu_run,
  output logic                   done,
  output logic                   error
);

  localparam int BPW = INSTR_WIDTH / 8;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_EMPTY = CSUM;
  localparam state_t AFTER_LOAD  = CSUM;
`else
  localparam state_t AFTER_EMPTY = DONE;
  localparam state_t AFTER_LOAD  = RUN;
`endif

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_n_hi;
  logic [ADDR_WIDTH-1:0] r_n;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_ready;
  logic                  r_run;
  logic                  r_done;
  logic                  w_fire;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_n;
  logic [ADDR_WIDTH-1:0] w_idx_nxt;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_xor;
  logic                  r_err;
`endif

  assign w_fire     = rx_valid && r_ready;
  assign w_n        = ADDR_WIDTH'({r_n_hi, rx_data});
  assign w_idx_nxt  = r_idx + ADDR_WIDTH'(1);
  assign rx_ready   = r_ready;
  assign cpu_run    = r_run;
  assign done       = r_done;
  assign imem_addr  = r_addr;

  byte_assembler #(
    .W   (INSTR_WIDTH),
    .BPW (BPW)
  ) u_asm (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_clear (r_state != LOAD),
    .i_push  (r_state == LOAD && w_fire),
    .i_byte  (rx_data),
    .o_last  (w_last),
    .o_valid (imem_we),
    .o_word  (imem_wdata)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CNT_HI: if (w_fire) w_next = CNT_LO;
      CNT_LO: if (w_fire) w_next = (w_n == '0) ? AFTER_EMPTY : LOAD;
      LOAD:   if (w_fire && w_last) w_next = WRITE;
      WRITE:  w_next = (w_idx_nxt == r_n) ? AFTER_LOAD : LOAD;
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (w_fire) begin
          if (rx_data != r_xor) w_next = ERROR;
          else if (r_n == '0)   w_next = DONE;
          else                  w_next = RUN;
        end
      end
`else
      CSUM:   w_next = ERROR;
`endif
      RUN:    if (pc >= r_n) w_next = DONE;
      DONE:   w_next = DONE;
      ERROR:  w_next = ERROR;
      default: w_next = CNT_HI;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CNT_HI;
      r_n_hi  <= '0;
      r_n     <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_ready <= 1'b0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= w_next inside {CNT_HI, CNT_LO, LOAD, CSUM};
      r_run   <= (w_next == RUN);
      r_done  <= (w_next == DONE);
      if (r_state == CNT_HI && w_fire) r_n_hi <= rx_data;
      if (r_state == CNT_LO && w_fire) r_n <= w_n;
      if (r_state == LOAD && w_fire && w_last) r_addr <= r_idx;
      if (r_state == WRITE) r_idx <= w_idx_nxt;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_xor <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == LOAD && w_fire) r_xor <= r_xor ^ rx_data;
      r_err <= (w_next == ERROR);
    end
  end

  assign error = r_err;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader with a stream-level reference model.
// Honours LOADER_CHECKSUM_EN to append and check the checksum byte.
`timescale 1ns/1ps
module tb_program_loader;

  localparam int AW = 16;
  localparam int IW = 32;

  typedef logic [7:0] bq_t[$];

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic [AW-1:0] pc = '0;
  logic          cpu_run;
  logic          done;
  logic          error;

  always #5 clock = ~clock;

  program_loader #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .pc         (pc),
    .cpu_run    (cpu_run),
    .done       (done),
    .error      (error)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: derives every expectation from the accepted bytes.
  int          cyc = 0;
  int          m_fired;
  int          m_n;
  logic [31:0] m_word;
  logic [7:0]  m_xor;
  bit          m_we, m_any, m_run, m_done, m_err;
  logic [15:0] m_addr;
  logic [31:0] m_data;
  bit          n_we, n_run, n_done, n_err;
  int          k;
  int          last_we_cyc, first_run_cyc, first_done_cyc, fire_cyc0;
  bit          seen_run, seen_we;
  logic [15:0] cap_addr[$];
  logic [31:0] cap_data[$];

  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      chk("reset_outputs",
          {rx_ready, imem_we, cpu_run, done, error, imem_addr, imem_wdata},
          '0);
      m_fired = 0; m_n = 0; m_word = '0; m_xor = '0;
      m_we = 0; m_any = 0; m_run = 0; m_done = 0; m_err = 0;
      m_addr = '0; m_data = '0;
    end else begin
      chk("imem_we", imem_we, m_we);
      if (m_we) begin
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wdata", imem_wdata, m_data);
        cap_addr.push_back(imem_addr);
        cap_data.push_back(imem_wdata);
        last_we_cyc = cyc;
        seen_we = 1;
      end else if (m_any) begin
        chk("addr_hold", imem_addr, m_addr);
        chk("wdata_hold", imem_wdata, m_data);
      end
      chk("cpu_run", cpu_run, m_run);
      chk("done", done, m_done);
      chk("error", error, m_err);
      if (m_run || m_done || m_err || m_we) chk("ready_low", rx_ready, 0);
      if (cpu_run && first_run_cyc < 0) first_run_cyc = cyc;
      if (cpu_run) seen_run = 1;
      if (done && first_done_cyc < 0) first_done_cyc = cyc;

      n_we = 0; n_run = m_run; n_done = m_done; n_err = m_err;
      if (m_we) m_any = 1;
`ifndef LOADER_CHECKSUM_EN
      if (m_we && int'(m_addr) == m_n - 1) n_run = 1;
`endif
      if (m_run && int'(pc) >= m_n) begin
        n_run = 0;
        n_done = 1;
      end
      if (rx_valid && rx_ready) begin
        k = m_fired;
        m_fired++;
        if (k == 0) begin
          m_n = int'(rx_data) * 256;
          fire_cyc0 = cyc;
        end else if (k == 1) begin
          m_n = m_n + int'(rx_data);
`ifndef LOADER_CHECKSUM_EN
          if (m_n == 0) n_done = 1;
`endif
        end else if (k < 2 + 4 * m_n) begin
          m_word = {m_word[23:0], rx_data};
          m_xor = m_xor ^ rx_data;
          if ((k - 2) % 4 == 3) begin
            n_we = 1;
            m_addr = 16'((k - 2) / 4);
            m_data = m_word;
          end
        end else begin
`ifdef LOADER_CHECKSUM_EN
          if (rx_data == m_xor) begin
            if (m_n == 0) n_done = 1;
            else n_run = 1;
          end else begin
            n_err = 1;
          end
`else
          chk("extra_accept", rx_ready, 0);
`endif
        end
      end
      m_we = n_we; m_run = n_run; m_done = n_done; m_err = n_err;
    end
  end

  function automatic bq_t build(input logic [31:0] w[$], input bit good);
    bq_t s;
    logic [7:0] x;
    x = '0;
    s.push_back(8'(w.size() >> 8));
    s.push_back(8'(w.size()));
    foreach (w[i]) begin
      for (int b = 3; b >= 0; b--) begin
        s.push_back(w[i][b*8 +: 8]);
        x = x ^ w[i][b*8 +: 8];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    s.push_back(good ? x : (x ^ 8'h01));
`else
    if (!good) s.push_back(x);
`endif
    return s;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx_valid = 1'b0;
    pc = '0;
    repeat (2) tick();
    cap_addr.delete();
    cap_data.delete();
    first_run_cyc = -1;
    first_done_cyc = -1;
    seen_run = 0;
    seen_we = 0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g;
    int t;
    bit rdy;
    g = $urandom_range(maxgap, 0);
    if (g > 0) begin
      rx_valid = 1'b0;
      repeat (g) tick();
    end
    rx_valid = 1'b1;
    rx_data = b;
    t = 0;
    forever begin
      @(negedge clock);
      rdy = rx_ready;
      tick();
      if (rdy) break;
      t++;
      if (t > 50) begin
        chk("accept_timeout", rdy, 1);
        break;
      end
    end
  endtask

  task automatic send_stream(input bq_t s, input int maxgap);
    foreach (s[i]) send_byte(s[i], maxgap);
    rx_valid = 1'b0;
  endtask

  task automatic end_program(input int n);
    int t;
    t = 0;
    while (!cpu_run && t < 200) begin
      tick();
      t++;
    end
    chk("run_reached", cpu_run, 1);
    pc = '0;
    t = 0;
    while (int'(pc) < n && t < 400) begin
      tick();
      t++;
      if ($urandom_range(1, 0) == 1) pc = pc + 16'd1;
    end
    tick();
    chk("end_done", done, 1);
    chk("end_run_low", cpu_run, 0);
    repeat (4) begin
      pc = 16'($urandom);
      tick();
    end
  endtask

  logic [31:0] words[$];
  bq_t         s;
  int          n;

  initial begin
    first_run_cyc = -1;
    first_done_cyc = -1;
    do_reset();
    chk("post_reset_ready", rx_ready, 1);

    // Two-word load, back-to-back.
    words = '{32'h8C410008, 32'h00221824};
    s = build(words, 1);
    chk("stream_len", s.size(),
`ifdef LOADER_CHECKSUM_EN
        11
`else
        10
`endif
        );
    send_stream(s, 0);
    repeat (3) tick();
    chk("t1_writes", cap_addr.size(), 2);
    if (cap_addr.size() == 2) begin
      chk("t1_addr0", cap_addr[0], 16'd0);
      chk("t1_data0", cap_data[0], 32'h8C410008);
      chk("t1_addr1", cap_addr[1], 16'd1);
      chk("t1_data1", cap_data[1], 32'h00221824);
    end
    chk("t1_run_latency", first_run_cyc - last_we_cyc,
`ifdef LOADER_CHECKSUM_EN
        2
`else
        1
`endif
        );

    // Program end: pc 0, 1, 2.
    pc = 16'd0;
    tick();
    pc = 16'd1;
    tick();
    chk("t3_run_at_pc1", cpu_run, 1);
    pc = 16'd2;
    tick();
    chk("t3_done", done, 1);
    chk("t3_run_fell", cpu_run, 0);
    pc = 16'd0;
    repeat (3) tick();
    chk("t3_done_sticky", done, 1);

    // Same stream, stalled.
    do_reset();
    send_stream(s, 3);
    repeat (3) tick();
    chk("t2_writes", cap_addr.size(), 2);
    if (cap_data.size() == 2) begin
      chk("t2_data0", cap_data[0], 32'h8C410008);
      chk("t2_data1", cap_data[1], 32'h00221824);
    end
    end_program(2);

    // Empty program.
    do_reset();
    words.delete();
    send_stream(build(words, 1), 0);
    repeat (4) tick();
    chk("t4_done", done, 1);
    chk("t4_done_latency", first_done_cyc - fire_cyc0,
`ifdef LOADER_CHECKSUM_EN
        3
`else
        2
`endif
        );
    chk("t4_no_we", seen_we, 0);
    chk("t4_no_run", seen_run, 0);

    // Reset in the middle of a load.
    do_reset();
    send_stream('{8'h00, 8'h01, 8'h8C, 8'h41}, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_zero",
        {rx_ready, imem_we, cpu_run, done, error, imem_addr, imem_wdata}, '0);
    do_reset();
    words = '{32'h12345678};
    send_stream(build(words, 1), 0);
    repeat (3) tick();
    chk("t5_writes", cap_addr.size(), 1);
    if (cap_addr.size() == 1) begin
      chk("t5_addr", cap_addr[0], 16'd0);
      chk("t5_data", cap_data[0], 32'h12345678);
    end
    end_program(1);

`ifdef LOADER_CHECKSUM_EN
    // Literal checksum streams.
    do_reset();
    send_stream('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08}, 0);
    repeat (2) tick();
    chk("t6_csum_run", cpu_run, 1);
    chk("t6_csum_err", error, 0);
    do_reset();
    send_stream('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09}, 0);
    repeat (3) tick();
    chk("t6_bad_err", error, 1);
    chk("t6_bad_run", cpu_run, 0);
    chk("t6_bad_seen_run", seen_run, 0);
`endif

    // Randomized programs.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      n = $urandom_range(6, 1);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      send_stream(build(words, 1), 3);
      repeat (3) tick();
      chk("rand_writes", cap_addr.size(), n);
      end_program(n);
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Hardware replacement for file-based memory preload and end-of-program detection around mips16bits.
- Receives a byte stream over a valid/ready link and assembles 32-bit instructions, MSB byte first.
- Writes the instructions sequentially into instruction memory, then releases the CPU to run.
- Stops the CPU and flags done when the program counter passes the last loaded instruction.

Parameters:
- INSTR_WIDTH, 32, instruction word width; must be a multiple of 8.
- ADDR_WIDTH, 16, instruction-memory word address, program counter and word-count width.

Ports:
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_WIDTH  word address of the write.
- imem_wdata  output  INSTR_WIDTH  assembled instruction.
- pc  input  ADDR_WIDTH  CPU program counter, as a word index.
- cpu_run  output  1  CPU enable; the CPU holds state while this is low.
- done  output  1  program finished; sticky until reset.
- error  output  1  checksum failure; sticky until reset.

Behaviour:
- Clock and reset:
  - One clock domain (clock).
  - Reset is asynchronous and active-low (reset_n).
  - While reset_n is low, every output is 0 and the state is CNT_HI.
  - Reset mid-operation immediately discards any partial word and the word count.
- Handshake:
  - A byte transfers on a rising edge when rx_valid && rx_ready.
  - rx_ready is a registered output, 1 only in CNT_HI, CNT_LO, LOAD and CSUM.
  - Gaps in rx_valid stall the loader with no side effects.
- Stream format: count N as 2 bytes big-endian, then N*4 payload bytes big-endian per word, then a checksum byte (feature only).
- States:
  - CNT_HI: accept byte -> N[15:8] -> CNT_LO.
  - CNT_LO: accept byte -> N[7:0].
    - If N==0 -> DONE; imem_we and cpu_run are never asserted.
    - Otherwise -> LOAD.
  - LOAD: shift bytes into the assembler. On the 4th accepted byte -> WRITE.
  - WRITE: lasts exactly one cycle.
    - imem_we=1, imem_addr=idx, imem_wdata=assembled word.
    - Then idx+1.
    - If idx+1==N -> RUN (or CSUM with the feature), else -> LOAD.
  - RUN: cpu_run=1 from the cycle after the last write. When pc >= N is sampled -> DONE.
  - DONE: cpu_run=0 and done=1 from the next edge. Absorbing; rx_ready=0.
  - ERROR: error=1, cpu_run=0. Absorbing.
- Widths:
  - idx is ADDR_WIDTH bits, so N ≤ 2^ADDR_WIDTH−1 and idx never wraps.
  - The pc comparison is unsigned.
- imem_addr and imem_wdata hold their last values when imem_we is 0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- With the macro:
  - A running XOR of all N*4 payload bytes is kept.
  - After the last WRITE the loader enters CSUM and accepts one byte.
  - Byte equals the XOR -> RUN. Mismatch -> ERROR.
  - N==0 still requires a checksum byte, expected 0x00, and on a match goes to DONE.
- Without the macro: no CSUM state, no checksum byte, error tied to 0.

Decomposition:
- Package loader_pkg:
  - State enum: CNT_HI, CNT_LO, LOAD, WRITE, CSUM, RUN, DONE, ERROR.
  - HEADER_BYTES=2.
  - BYTES_PER_WORD=INSTR_WIDTH/8.
- One sub-module, byte_assembler:
  - Shift register plus byte counter.
  - Presents a word-complete pulse and the assembled word.
  - Has its own clear input.

Test Plan:
- Two-word load:
  - Stimulus: 00 02 8C 41 00 08 00 22 18 24, sent back-to-back.
  - Response: a single-cycle imem_we at addr 0 with data 0x8C410008, then at addr 1 with 0x00221824.
  - cpu_run rises one cycle after the second write.
- Stalled stream: same stream with random 0–3 idle cycles between bytes -> identical writes and identical data; no spurious imem_we.
- Program end: after test 1, drive pc 0, 1, 2 -> cpu_run falls and done rises on the edge after pc==2. Further pc changes have no effect.
- Empty program: 00 00 -> done=1 two edges after the first byte; imem_we never 1; cpu_run never 1.
- Reset mid-load:
  - Stimulus: reset_n low after 00 01 8C 41; then release and send 00 01 12 34 56 78.
  - Response: outputs go to 0 asynchronously while reset_n is low, then exactly one write of 0x12345678 at addr 0.
- Checksum (feature on):
  - Stimulus: 00 01 12 34 56 78 08 -> RUN. Same stream ending in 09 -> error=1, cpu_run stays 0.
  - Response: the correct byte 0x08 (the XOR of the four payload bytes) reaches RUN; the wrong byte 0x09 raises error.
